// File: rtl/salsa_blockmix_if.sv
// Block-level handshake bundle for salsa_blockmix: 1024-bit input block in, {Y1,Y0} result and
// integerify index out. The slave modport is the blockmix view; the master modport is the upstream/downstream view.
interface salsa_blockmix_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1023:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [1023:0]     out_data;
    logic [ADDR_W-1:0] j_addr;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, j_addr
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, j_addr
    );
endinterface

// File: rtl/salsa_blockmix.sv
// scrypt BlockMix (r=1) sequencer around an external two-stage double-round salsa_core.
// Optional input holding register enabled by defining SALSA_BLOCKMIX_INBUF_EN.
module salsa_blockmix #(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    salsa_blockmix_if.slave bus,
    output logic            busy,
    output logic [511:0]    sc_xx,
    input  logic [511:0]    sc_out
);
    typedef enum logic [1:0] {IDLE, MIX0, MIX1, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic [511:0]  z, x1, y0, y1;
    logic [511:0]  sum;
    logic          accept, last, start;
    logic [1023:0] start_blk;

    function automatic logic [511:0] add_words(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
        return r;
    endfunction

    // Four double rounds are complete when cnt reaches 8; the feed-forward add uses the current Z.
    assign sum    = add_words(z, sc_out);
    assign last   = (cnt == 4'd8);
    assign accept = bus.in_valid && bus.in_ready;

`ifdef SALSA_BLOCKMIX_INBUF_EN
    logic [1023:0] buf_data;
    logic          full;
    logic          from_buf;

    assign bus.in_ready = !full;
    // A parked block starts straight from DONE (or from IDLE if it arrived during the DONE handshake).
    assign from_buf  = full && (state == IDLE || (state == DONE && bus.out_ready));
    assign start     = from_buf || (state == IDLE && accept);
    assign start_blk = from_buf ? buf_data : bus.in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data <= '0;
            full     <= 1'b0;
        end else if (accept && state != IDLE) begin
            buf_data <= bus.in_data;
            full     <= 1'b1;
        end else if (from_buf) begin
            full     <= 1'b0;
        end
    end
`else
    assign bus.in_ready = (state == IDLE);
    assign start        = accept;
    assign start_blk    = bus.in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next-state is assigned its hold value first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MIX0;
            MIX0:    if (last) state_nxt = MIX1;
            MIX1:    if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = start ? MIX0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the wide datapath registers are reset too, because out_data, j_addr and sc_xx must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
            z   <= '0;
            x1  <= '0;
            y0  <= '0;
            y1  <= '0;
        end else if (start) begin
            z   <= start_blk[511:0] ^ start_blk[1023:512];
            x1  <= start_blk[1023:512];
            cnt <= 4'd0;
        end else if (busy) begin
            cnt <= last ? 4'd0 : cnt + 4'd1;
            if (last && state == MIX0) begin
                y0 <= sum;
                z  <= sum ^ x1;
            end
            if (last && state == MIX1) y1 <= sum;
        end
    end

    assign busy          = (state == MIX0) || (state == MIX1);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = {y1, y0};
    assign bus.j_addr    = y1[ADDR_W-1:0];
    // Even cycles feed the core's previous double round back in; odd-cycle results chase stale data and are never captured.
    assign sc_xx         = (busy && cnt != 4'd0) ? sc_out : z;
endmodule

// File: tb/tb_salsa_blockmix.sv
// Self-checking bench for salsa_blockmix: emulates the two-stage core, scoreboards against a
// Salsa20/8 BlockMix software model, and runs directed reset/latency/backpressure cases plus a random soak.
module tb_salsa_blockmix;
    localparam int ADDR_W = 10;

    localparam logic [511:0] RFC_IN = {
        32'h5ec2b8b8, 32'h8dc6ebed, 32'h2948c709, 32'h291d0276,
        32'h32aac55a, 32'h4b1e1214, 32'h853d9bdf, 32'h19f324ee,
        32'h1d3bcd6d, 32'h1146f80d, 32'hb5c1618c, 32'h5b55eeba,
        32'h268f7141, 32'he640a97c, 32'h86c93e4f, 32'h219a877e};

    localparam int QR[8][4] = '{
        '{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11},
        '{0, 1, 2, 3},  '{5, 6, 7, 4},  '{10, 11, 8, 9}, '{15, 12, 13, 14}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    salsa_blockmix_if #(.ADDR_W(ADDR_W)) bus ();
    logic         busy;
    logic [511:0] sc_xx;
    logic [511:0] sc_out;

    salsa_blockmix #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .sc_xx(sc_xx), .sc_out(sc_out));

    int            n_cmp = 0;
    int            n_err = 0;
    logic [1023:0] exp_q[$];
    logic [1023:0] head;
    bit            prod_done;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] dr(input logic [511:0] b);
        logic [31:0]  x[16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = b[32*i +: 32];
        for (int q = 0; q < 8; q++) begin
            x[QR[q][1]] ^= rotl(x[QR[q][0]] + x[QR[q][3]], 7);
            x[QR[q][2]] ^= rotl(x[QR[q][1]] + x[QR[q][0]], 9);
            x[QR[q][3]] ^= rotl(x[QR[q][2]] + x[QR[q][1]], 13);
            x[QR[q][0]] ^= rotl(x[QR[q][3]] + x[QR[q][2]], 18);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i];
        return r;
    endfunction

    function automatic logic [511:0] salsa20_8(input logic [511:0] b);
        logic [511:0] t = b;
        logic [511:0] r;
        for (int k = 0; k < 4; k++) t = dr(t);
        for (int i = 0; i < 16; i++) r[32*i +: 32] = b[32*i +: 32] + t[32*i +: 32];
        return r;
    endfunction

    function automatic logic [1023:0] blockmix(input logic [1023:0] blk);
        logic [511:0] y0, y1;
        y0 = salsa20_8(blk[511:0] ^ blk[1023:512]);
        y1 = salsa20_8(y0 ^ blk[1023:512]);
        return {y1, y0};
    endfunction

    function automatic logic [1023:0] rand_blk();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Core stand-in: registered input, then one double round registered on the output.
    logic [511:0] core_s1 = '0;
    logic [511:0] core_s2 = '0;
    always @(posedge clk) begin
        core_s1 <= sc_xx;
        core_s2 <= dr(core_s1);
    end
    assign sc_out = core_s2;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        int w;
        w = 0;
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            for (int i = 31; i >= 0; i--) if (act[32*i +: 32] !== exp[32*i +: 32]) w = i;
            $display("FAIL %s: word %0d got %h want %h", name, w, act[32*w +: 32], exp[32*w +: 32]);
        end
    endtask

    // Scoreboard: expected results queued at input handshakes, checked every cycle out_valid is high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) exp_q.push_back(blockmix(bus.in_data));
            if (bus.out_valid) begin
                check("out_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    head = exp_q[0];
                    check("out_data", bus.out_data, head);
                    check("j_addr", bus.j_addr, head[512 +: ADDR_W]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1023:0] d);
        int g;
        g = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 200) begin
            tick();
            g++;
        end
        if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int g;
        g = 0;
        while (!bus.out_valid && g < 100) begin
            tick();
            g++;
        end
        if (!bus.out_valid) check("out_valid_timeout", bus.out_valid, 1);
    endtask

    // Called one step after the start edge; out_valid must rise on exactly the 18th edge after it.
    task automatic latency18();
        tick();
        check("busy_after_start", busy, 1);
        repeat (16) tick();
        check("lat_before_18", bus.out_valid, 0);
        tick();
        check("lat_at_18", bus.out_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_j_addr"}, bus.j_addr, 0);
        check({tag, "_sc_xx"}, sc_xx, 0);
        check({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        logic [511:0]        m;
        logic [1023:0]       snap;
        logic [ADDR_W-1:0]   snap_j;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        prod_done     = 1'b0;

        // Pin the model to published values before trusting it as a reference.
        m = salsa20_8(RFC_IN);
        check("model_rfc_w0", m[31:0], 32'h9c851fa4);
        check("model_rfc_w1", m[63:32], 32'h99cc0866);
        check("model_zero", blockmix('0), 0);

        #12;
        check_reset_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_outputs("after_reset");

        // All-zero block: result is zero, latency 18, ready again right after the handshake.
        bus.out_ready = 1'b1;
        send('0);
        latency18();
        check("zero_out_data", bus.out_data, 0);
        check("zero_j_addr", bus.j_addr, 0);
        tick();
        check("zero_out_dropped", bus.out_valid, 0);
        check("zero_in_ready", bus.in_ready, 1);

        // RFC 7914 vector in X0 with X1 = 0, then hold the result under backpressure.
        bus.out_ready = 1'b0;
        send({512'd0, RFC_IN});
        wait_out();
        snap   = bus.out_data;
        snap_j = bus.j_addr;
        check("rfc_y0_w0", snap[31:0], 32'h9c851fa4);
        check("rfc_y0_w1", snap[63:32], 32'h99cc0866);
        repeat (5) begin
            tick();
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_out_data", bus.out_data, snap);
            check("hold_j_addr", bus.j_addr, snap_j);
`ifndef SALSA_BLOCKMIX_INBUF_EN
            check("hold_in_ready", bus.in_ready, 0);
`endif
        end
        bus.out_ready = 1'b1;
        tick();
        check("rfc_out_dropped", bus.out_valid, 0);

        // Reset during MIX1 with cnt==4, then a fresh block after release.
        send(rand_blk());
        repeat (13) tick();
        check("pre_reset_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(rand_blk());
        latency18();
        tick();

`ifdef SALSA_BLOCKMIX_INBUF_EN
        // Second block parked during MIX0 starts on the first output handshake edge.
        bus.out_ready = 1'b0;
        send(rand_blk());
        tick();
        tick();
        send(rand_blk());
        check("buf_in_ready_low", bus.in_ready, 0);
        wait_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        latency18();
        bus.out_ready = 1'b1;
        tick();
`endif

        // Random soak with idle gaps and random backpressure.
        fork
            begin
                for (int t = 0; t < 1000; t++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(rand_blk());
                end
                prod_done = 1'b1;
            end
            begin
                int g;
                g = 0;
                while ((!prod_done || exp_q.size() != 0) && g < 60000) begin
                    bus.out_ready = ($urandom_range(0, 1) == 1);
                    tick();
                    g++;
                end
            end
        join
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("drain_empty", exp_q.size(), 0);
        check("final_idle", bus.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
